// File: rtl/demux_pkg.sv
// Shared flit encodings, field positions and receive-FSM states for the port_0 mux/demux pair.
package demux_pkg;

    localparam int DATA_W = 134;

    localparam int TYPE_HI = 133;
    localparam int TYPE_LO = 132;
    localparam int MID_HI  = 127;
    localparam int MID_LO  = 120;

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_MID  = 2'b11;
    localparam logic [1:0] FT_TAIL = 2'b10;
    localparam logic [1:0] FT_NONE = 2'b00;

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        LCM_RECV_S = 2'd1,
        SSM_RECV_S = 2'd2,
        DROP_S     = 2'd3
    } state_t;

    // One destination's registered output bundle.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              wr;
        logic              valid;
        logic              valid_wr;
    } port_out_t;

    function automatic logic [1:0] flit_type(input logic [DATA_W-1:0] flit);
        return flit[TYPE_HI:TYPE_LO];
    endfunction

    function automatic logic [7:0] flit_mid(input logic [DATA_W-1:0] flit);
        return flit[MID_HI:MID_LO];
    endfunction

endpackage

// File: rtl/demux_if.sv
// Flit bus between port_0 and the demux, plus the demux's LCM and SSM output buses.
interface demux_if;
    import demux_pkg::*;

    logic [DATA_W-1:0] port2demux_data;
    logic              port2demux_data_wr;
    logic              port2demux_data_valid;
    logic              port2demux_data_valid_wr;
    logic              lcm_data_ready;
    logic              ssm_data_ready;

    logic [DATA_W-1:0] demux2lcm_data;
    logic              demux2lcm_data_wr;
    logic              demux2lcm_data_valid;
    logic              demux2lcm_data_valid_wr;

    logic [DATA_W-1:0] demux2ssm_data;
    logic              demux2ssm_data_wr;
    logic              demux2ssm_data_valid;
    logic              demux2ssm_data_valid_wr;

    modport master (
        output port2demux_data, port2demux_data_wr,
        output port2demux_data_valid, port2demux_data_valid_wr,
        output lcm_data_ready, ssm_data_ready,
        input  demux2lcm_data, demux2lcm_data_wr,
        input  demux2lcm_data_valid, demux2lcm_data_valid_wr,
        input  demux2ssm_data, demux2ssm_data_wr,
        input  demux2ssm_data_valid, demux2ssm_data_valid_wr
    );

    modport slave (
        input  port2demux_data, port2demux_data_wr,
        input  port2demux_data_valid, port2demux_data_valid_wr,
        input  lcm_data_ready, ssm_data_ready,
        output demux2lcm_data, demux2lcm_data_wr,
        output demux2lcm_data_valid, demux2lcm_data_valid_wr,
        output demux2ssm_data, demux2ssm_data_wr,
        output demux2ssm_data_valid, demux2ssm_data_valid_wr
    );

endinterface

// File: rtl/demux_stat_cnt.sv
// Free-running statistics counter: synchronous clear, single-step increment, wraps at 2^CNT_W.
module demux_stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux.sv
// Steers whole packets from port_0 to the LCM or SSM by head module ID; drops rather than stalls.
module demux
    import demux_pkg::*;
#(
    parameter        PLATFOMR = "Xilinx-OpenBox-S4",
    parameter logic [7:0] LMID = 8'd5,
    parameter int    CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    demux_if.slave           bus,
    output logic [CNT_W-1:0] lcm_pkt_cnt,
    output logic [CNT_W-1:0] ssm_pkt_cnt,
    output logic [CNT_W-1:0] drop_pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // Platform tag is informational; it selects no logic.
    if (PLATFOMR == "") begin : g_untagged_platform
    end

    state_t            state, state_n;
    port_out_t         lcm_n, ssm_n, cur_n;
    port_out_t         lcm_p1, ssm_p1;
    logic              inc_lcm, inc_ssm, inc_drop, inc_err, inc_pkt;
    logic [DATA_W-1:0] flit;
    logic [1:0]        ftype;
    logic              to_lcm;
    logic              tail_valid;

    assign flit       = bus.port2demux_data;
    assign ftype      = flit_type(flit);
    assign to_lcm     = (flit_mid(flit) == LMID);
    assign tail_valid = bus.port2demux_data_valid_wr ? bus.port2demux_data_valid : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE_S;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        lcm_n    = '0;
        ssm_n    = '0;
        cur_n    = '0;
        inc_lcm  = 1'b0;
        inc_ssm  = 1'b0;
        inc_drop = 1'b0;
        inc_err  = 1'b0;
        inc_pkt  = 1'b0;
        if (bus.port2demux_data_wr) begin
            case (state)
                IDLE_S, DROP_S: begin
                    if (ftype == FT_HEAD) begin
                        // A head while discarding means the previous packet lost its tail.
                        if (state == DROP_S) inc_err = 1'b1;
                        if (to_lcm && bus.lcm_data_ready) begin
                            lcm_n.data = flit;
                            lcm_n.wr   = 1'b1;
                            state_n    = LCM_RECV_S;
                        end else if (!to_lcm && bus.ssm_data_ready) begin
                            ssm_n.data = flit;
                            ssm_n.wr   = 1'b1;
                            state_n    = SSM_RECV_S;
                        end else begin
                            inc_drop = 1'b1;
                            state_n  = DROP_S;
                        end
                    end else if (state == IDLE_S) begin
                        inc_err = 1'b1;
                    end else if (ftype == FT_TAIL) begin
                        state_n = IDLE_S;
                    end else if (ftype == FT_NONE) begin
                        inc_err = 1'b1;
                        state_n = IDLE_S;
                    end
                end
                LCM_RECV_S, SSM_RECV_S: begin
                    case (ftype)
                        FT_MID: begin
                            cur_n.data = flit;
                            cur_n.wr   = 1'b1;
                        end
                        FT_TAIL: begin
                            cur_n.data     = flit;
                            cur_n.wr       = 1'b1;
                            cur_n.valid    = tail_valid;
                            cur_n.valid_wr = 1'b1;
                            inc_pkt        = tail_valid;
                            state_n        = IDLE_S;
                        end
                        FT_HEAD: begin
                            // Abort: close the open packet as bad without writing data.
                            cur_n.valid_wr = 1'b1;
                            inc_err        = 1'b1;
                            state_n        = DROP_S;
                        end
                        default: begin
                            cur_n.valid_wr = 1'b1;
                            inc_err        = 1'b1;
                            state_n        = IDLE_S;
                        end
                    endcase
                    if (state == LCM_RECV_S) begin
                        lcm_n   = cur_n;
                        inc_lcm = inc_pkt;
                    end else begin
                        ssm_n   = cur_n;
                        inc_ssm = inc_pkt;
                    end
                end
                default: state_n = IDLE_S;
            endcase
        end
    end

    // Output stage: one cycle from input flit to destination flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcm_p1 <= '0;
            ssm_p1 <= '0;
        end else begin
            lcm_p1 <= lcm_n;
            ssm_p1 <= ssm_n;
        end
    end

    assign bus.demux2lcm_data          = lcm_p1.data;
    assign bus.demux2lcm_data_wr       = lcm_p1.wr;
    assign bus.demux2lcm_data_valid    = lcm_p1.valid;
    assign bus.demux2lcm_data_valid_wr = lcm_p1.valid_wr;
    assign bus.demux2ssm_data          = ssm_p1.data;
    assign bus.demux2ssm_data_wr       = ssm_p1.wr;
    assign bus.demux2ssm_data_valid    = ssm_p1.valid;
    assign bus.demux2ssm_data_valid_wr = ssm_p1.valid_wr;

    demux_stat_cnt #(.CNT_W(CNT_W)) u_lcm_cnt (
        .clk(clk), .clr(rst), .inc(inc_lcm), .cnt(lcm_pkt_cnt)
    );
    demux_stat_cnt #(.CNT_W(CNT_W)) u_ssm_cnt (
        .clk(clk), .clr(rst), .inc(inc_ssm), .cnt(ssm_pkt_cnt)
    );
    demux_stat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk(clk), .clr(rst), .inc(inc_drop), .cnt(drop_pkt_cnt)
    );
    demux_stat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk(clk), .clr(rst), .inc(inc_err), .cnt(err_cnt)
    );

endmodule

// File: tb/tb_demux.sv
// Directed per-cycle vector bench for demux: each record drives one cycle and states the registered result.
module tb_demux;
    import demux_pkg::*;

    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] M = 2'b11;
    localparam logic [1:0] T = 2'b10;
    localparam logic [1:0] N = 2'b00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lcm_pkt_cnt, ssm_pkt_cnt, drop_pkt_cnt, err_cnt;
    logic        both_seen = 1'b0;
    int          applied = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    demux_if bus();

    demux #(.LMID(8'd5), .CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .lcm_pkt_cnt(lcm_pkt_cnt),
        .ssm_pkt_cnt(ssm_pkt_cnt),
        .drop_pkt_cnt(drop_pkt_cnt),
        .err_cnt(err_cnt)
    );

    always @(negedge clk) begin
        if (bus.demux2lcm_data_wr && bus.demux2ssm_data_wr) both_seen = 1'b1;
    end

    typedef struct {
        string      name;
        logic       r;
        logic       wr;
        logic [1:0] ft;
        logic [7:0] id;
        logic [7:0] tag;
        logic       v;
        logic       vwr;
        logic       lr;
        logic       sr;
        logic [2:0] el;   // {wr, valid, valid_wr} expected on LCM
        logic [2:0] es;   // {wr, valid, valid_wr} expected on SSM
        int         lc, sc, dc, ec;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string name, input logic r, input logic wr,
                                input logic [1:0] ft, input logic [7:0] id, input logic [7:0] tag,
                                input logic v, input logic vwr, input logic lr, input logic sr,
                                input logic [2:0] el, input logic [2:0] es,
                                input int lc, input int sc, input int dc, input int ec);
        vec_t x;
        x.name = name; x.r = r; x.wr = wr; x.ft = ft; x.id = id; x.tag = tag;
        x.v = v; x.vwr = vwr; x.lr = lr; x.sr = sr; x.el = el; x.es = es;
        x.lc = lc; x.sc = sc; x.dc = dc; x.ec = ec;
        return x;
    endfunction

    function automatic logic [133:0] mkdata(input logic [1:0] ft, input logic [7:0] id,
                                            input logic [7:0] tag);
        return {ft, 4'h0, id, 112'h0, tag};
    endfunction

    task automatic drive(input logic r, input logic wr, input logic [1:0] ft, input logic [7:0] id,
                         input logic [7:0] tag, input logic v, input logic vwr,
                         input logic lr, input logic sr);
        rst                          = r;
        bus.port2demux_data          = mkdata(ft, id, tag);
        bus.port2demux_data_wr       = wr;
        bus.port2demux_data_valid    = v;
        bus.port2demux_data_valid_wr = vwr;
        bus.lcm_data_ready           = lr;
        bus.ssm_data_ready           = sr;
    endtask

    task automatic check(input string name, input logic [2:0] el, input logic [2:0] es,
                         input logic [133:0] d, input int lc, input int sc, input int dc,
                         input int ec);
        logic [2:0]   al, as;
        logic [133:0] eld, esd;
        al  = {bus.demux2lcm_data_wr, bus.demux2lcm_data_valid, bus.demux2lcm_data_valid_wr};
        as  = {bus.demux2ssm_data_wr, bus.demux2ssm_data_valid, bus.demux2ssm_data_valid_wr};
        eld = el[2] ? d : '0;
        esd = es[2] ? d : '0;
        applied++;
        if (al !== el || as !== es || bus.demux2lcm_data !== eld || bus.demux2ssm_data !== esd ||
            lcm_pkt_cnt !== 32'(lc) || ssm_pkt_cnt !== 32'(sc) ||
            drop_pkt_cnt !== 32'(dc) || err_cnt !== 32'(ec)) begin
            miscompares++;
            $display("FAIL %s: got lcm=%b ssm=%b cnt=%0d/%0d/%0d/%0d ld=%h sd=%h; want lcm=%b ssm=%b cnt=%0d/%0d/%0d/%0d ld=%h sd=%h",
                     name, al, as, lcm_pkt_cnt, ssm_pkt_cnt, drop_pkt_cnt, err_cnt,
                     bus.demux2lcm_data, bus.demux2ssm_data, el, es, lc, sc, dc, ec, eld, esd);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, N, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        //        name              r  wr ft id  tag v  vwr lr sr  el      es     lc sc dc ec
        vq.push_back(mk("reset",          1, 1, H, 5,  0, 0, 0, 1, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        vq.push_back(mk("idle",           0, 0, N, 0,  0, 0, 0, 1, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        vq.push_back(mk("lcm_head",       0, 1, H, 5,  1, 0, 0, 1, 1, 3'b100, 3'b000, 0, 0, 0, 0));
        vq.push_back(mk("lcm_mid",        0, 1, M, 0,  2, 0, 0, 1, 1, 3'b100, 3'b000, 0, 0, 0, 0));
        vq.push_back(mk("lcm_tail",       0, 1, T, 0,  3, 1, 1, 1, 1, 3'b111, 3'b000, 1, 0, 0, 0));
        vq.push_back(mk("idle2",          0, 0, N, 0,  0, 0, 0, 1, 1, 3'b000, 3'b000, 1, 0, 0, 0));
        vq.push_back(mk("ssm_head",       0, 1, H, 9,  4, 0, 0, 1, 1, 3'b000, 3'b100, 1, 0, 0, 0));
        vq.push_back(mk("ssm_mid1",       0, 1, M, 0,  5, 0, 0, 1, 1, 3'b000, 3'b100, 1, 0, 0, 0));
        vq.push_back(mk("ssm_gap1",       0, 0, H, 5,  6, 0, 0, 1, 1, 3'b000, 3'b000, 1, 0, 0, 0));
        vq.push_back(mk("ssm_gap2",       0, 0, M, 0,  7, 0, 0, 1, 1, 3'b000, 3'b000, 1, 0, 0, 0));
        vq.push_back(mk("ssm_mid2",       0, 1, M, 0,  8, 0, 0, 1, 1, 3'b000, 3'b100, 1, 0, 0, 0));
        vq.push_back(mk("ssm_tail",       0, 1, T, 0,  9, 1, 1, 1, 1, 3'b000, 3'b111, 1, 1, 0, 0));
        vq.push_back(mk("drop_head",      0, 1, H, 5, 10, 0, 0, 0, 1, 3'b000, 3'b000, 1, 1, 1, 0));
        vq.push_back(mk("drop_mid1",      0, 1, M, 0, 11, 0, 0, 0, 1, 3'b000, 3'b000, 1, 1, 1, 0));
        vq.push_back(mk("drop_mid2",      0, 1, M, 0, 12, 0, 0, 0, 1, 3'b000, 3'b000, 1, 1, 1, 0));
        vq.push_back(mk("drop_mid3",      0, 1, M, 0, 13, 0, 0, 0, 1, 3'b000, 3'b000, 1, 1, 1, 0));
        vq.push_back(mk("drop_tail",      0, 1, T, 0, 14, 1, 1, 0, 1, 3'b000, 3'b000, 1, 1, 1, 0));
        vq.push_back(mk("relcm_head",     0, 1, H, 5, 15, 0, 0, 1, 1, 3'b100, 3'b000, 1, 1, 1, 0));
        vq.push_back(mk("relcm_tail",     0, 1, T, 0, 16, 1, 1, 1, 1, 3'b111, 3'b000, 2, 1, 1, 0));
        vq.push_back(mk("tv_head",        0, 1, H, 5, 17, 0, 0, 1, 1, 3'b100, 3'b000, 2, 1, 1, 0));
        vq.push_back(mk("tv_tail_novwr",  0, 1, T, 0, 18, 0, 0, 1, 1, 3'b111, 3'b000, 3, 1, 1, 0));
        vq.push_back(mk("bad_head",       0, 1, H, 9, 19, 0, 0, 1, 1, 3'b000, 3'b100, 3, 1, 1, 0));
        vq.push_back(mk("bad_tail",       0, 1, T, 0, 20, 0, 1, 1, 1, 3'b000, 3'b101, 3, 1, 1, 0));
        vq.push_back(mk("trunc_head",     0, 1, H, 9, 21, 0, 0, 1, 1, 3'b000, 3'b100, 3, 1, 1, 0));
        vq.push_back(mk("trunc_mid",      0, 1, M, 0, 22, 0, 0, 1, 1, 3'b000, 3'b100, 3, 1, 1, 0));
        vq.push_back(mk("trunc_new_head", 0, 1, H, 9, 23, 0, 0, 1, 1, 3'b000, 3'b001, 3, 1, 1, 1));
        vq.push_back(mk("trunc_drop_mid", 0, 1, M, 0, 24, 0, 0, 1, 1, 3'b000, 3'b000, 3, 1, 1, 1));
        vq.push_back(mk("trunc_drop_tl",  0, 1, T, 0, 25, 1, 1, 1, 1, 3'b000, 3'b000, 3, 1, 1, 1));
        vq.push_back(mk("post_head",      0, 1, H, 7, 26, 0, 0, 1, 1, 3'b000, 3'b100, 3, 1, 1, 1));
        vq.push_back(mk("post_tail",      0, 1, T, 0, 27, 1, 1, 1, 1, 3'b000, 3'b111, 3, 2, 1, 1));
        vq.push_back(mk("orphan_mid",     0, 1, M, 0, 28, 0, 0, 1, 1, 3'b000, 3'b000, 3, 2, 1, 2));
        vq.push_back(mk("orphan_tail",    0, 1, T, 0, 29, 1, 1, 1, 1, 3'b000, 3'b000, 3, 2, 1, 3));
        vq.push_back(mk("none_head",      0, 1, H, 5, 30, 0, 0, 1, 1, 3'b100, 3'b000, 3, 2, 1, 3));
        vq.push_back(mk("none_abort",     0, 1, N, 0, 31, 0, 0, 1, 1, 3'b001, 3'b000, 3, 2, 1, 4));
        vq.push_back(mk("none_idle",      0, 1, N, 0, 32, 0, 0, 1, 1, 3'b000, 3'b000, 3, 2, 1, 5));
        vq.push_back(mk("dh_drop",        0, 1, H, 5, 33, 0, 0, 0, 1, 3'b000, 3'b000, 3, 2, 2, 5));
        vq.push_back(mk("dh_head",        0, 1, H, 9, 34, 0, 0, 0, 1, 3'b000, 3'b100, 3, 2, 2, 6));
        vq.push_back(mk("dh_tail",        0, 1, T, 0, 35, 1, 1, 0, 1, 3'b000, 3'b111, 3, 3, 2, 6));
        vq.push_back(mk("dd_drop1",       0, 1, H, 5, 36, 0, 0, 0, 1, 3'b000, 3'b000, 3, 3, 3, 6));
        vq.push_back(mk("dd_drop2",       0, 1, H, 5, 37, 0, 0, 0, 1, 3'b000, 3'b000, 3, 3, 4, 7));
        vq.push_back(mk("dd_none",        0, 1, N, 0, 38, 0, 0, 0, 1, 3'b000, 3'b000, 3, 3, 4, 8));
        vq.push_back(mk("dd_ssm_drop",    0, 1, H, 9, 39, 0, 0, 1, 0, 3'b000, 3'b000, 3, 3, 5, 8));
        vq.push_back(mk("dd_tail",        0, 1, T, 0, 40, 1, 1, 1, 0, 3'b000, 3'b000, 3, 3, 5, 8));
        vq.push_back(mk("rdy_head",       0, 1, H, 5, 41, 0, 0, 1, 1, 3'b100, 3'b000, 3, 3, 5, 8));
        vq.push_back(mk("rdy_mid",        0, 1, M, 0, 42, 0, 0, 0, 0, 3'b100, 3'b000, 3, 3, 5, 8));
        vq.push_back(mk("rdy_tail",       0, 1, T, 0, 43, 1, 1, 0, 0, 3'b111, 3'b000, 4, 3, 5, 8));
        vq.push_back(mk("rst_head",       0, 1, H, 5, 44, 0, 0, 1, 1, 3'b100, 3'b000, 4, 3, 5, 8));
        vq.push_back(mk("rst_pulse",      1, 0, M, 0, 45, 0, 0, 1, 1, 3'b000, 3'b000, 0, 0, 0, 0));
        vq.push_back(mk("rst_mid",        0, 1, M, 0, 46, 0, 0, 1, 1, 3'b000, 3'b000, 0, 0, 0, 1));
        vq.push_back(mk("rst_tail",       0, 1, T, 0, 47, 1, 1, 1, 1, 3'b000, 3'b000, 0, 0, 0, 2));
        vq.push_back(mk("rst_after",      0, 1, H, 9, 48, 0, 0, 1, 1, 3'b000, 3'b100, 0, 0, 0, 2));

        foreach (vq[i]) begin
            drive(vq[i].r, vq[i].wr, vq[i].ft, vq[i].id, vq[i].tag, vq[i].v, vq[i].vwr,
                  vq[i].lr, vq[i].sr);
            @(posedge clk);
            #1;
            check(vq[i].name, vq[i].el, vq[i].es, mkdata(vq[i].ft, vq[i].id, vq[i].tag),
                  vq[i].lc, vq[i].sc, vq[i].dc, vq[i].ec);
        end

        // Close the open SSM packet, then three back-to-back LCM packets with no idle cycles.
        drive(1'b0, 1'b1, T, 8'd0, 8'd50, 1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("b2b_ssm_close", 3'b000, 3'b111, mkdata(T, 8'd0, 8'd50), 0, 1, 0, 2);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, H, 8'd5, 8'(60 + 2 * k), 1'b0, 1'b0, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            check("b2b_head", 3'b100, 3'b000, mkdata(H, 8'd5, 8'(60 + 2 * k)), k, 1, 0, 2);
            drive(1'b0, 1'b1, T, 8'd0, 8'(61 + 2 * k), 1'b1, 1'b1, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            check("b2b_tail", 3'b111, 3'b000, mkdata(T, 8'd0, 8'(61 + 2 * k)), k + 1, 1, 0, 2);
        end

        drive(1'b0, 1'b0, N, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        applied++;
        if (both_seen) begin
            miscompares++;
            $display("FAIL exclusive_write: got both destinations written in one cycle, want never");
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/demux.md
Name: demux

Overview:
- Receive-side counterpart of the port_0 output multiplexer. Accepts 134-bit packets arriving from port_0 and steers each whole packet to either the LCM or the SSM.
- Steering key: destination module ID in the head flit, compared against LMID.
- Packets are dropped, never stalled, when the chosen destination cannot accept them. Malformed flit sequences are repaired by aborting or discarding packets.
- Provides packet, drop and error counters.

Parameters:
- PLATFOMR, "Xilinx-OpenBox-S4", platform tag; no functional effect.
- LMID, 8'd5, module ID owned by the LCM. A head with data[127:120]==LMID goes to the LCM; any other value goes to the SSM.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- port2demux_data  in  134  flit; [133:132]: 01 head, 11 middle, 10 tail, 00 invalid
- port2demux_data_wr  in  1  flit strobe
- port2demux_data_valid  in  1  packet-good flag, meaningful with valid_wr
- port2demux_data_valid_wr  in  1  asserted in the tail cycle
- lcm_data_ready  in  1  LCM can take one full packet
- ssm_data_ready  in  1  SSM can take one full packet
- demux2lcm_data  out  134 / demux2lcm_data_wr  out  1 / demux2lcm_data_valid  out  1 / demux2lcm_data_valid_wr  out  1
- demux2ssm_data  out  134 / demux2ssm_data_wr  out  1 / demux2ssm_data_valid  out  1 / demux2ssm_data_valid_wr  out  1
- lcm_pkt_cnt  out  CNT_W  packets delivered good to the LCM
- ssm_pkt_cnt  out  CNT_W  packets delivered good to the SSM
- drop_pkt_cnt  out  CNT_W  heads dropped because the destination was not ready
- err_cnt  out  CNT_W  protocol errors

Behaviour:
- Reset:
  - Single clock, clk. Reset is synchronous and active-high on rst.
  - Every output register clears to 0 and all counters clear to 0. State goes to IDLE_S.
  - Reset mid-packet discards the packet silently; no abort is emitted.
- Output timing:
  - All outputs are registered, so latency is 1 cycle from input flit to output flit.
  - Data is forwarded unmodified.
  - In any cycle without a write to a destination, that destination's data is 0 and its wr, valid and valid_wr are 0.
- Sampling: port2demux_data_wr=0 holds the state and emits nothing. Flits are examined only when data_wr=1.
- Ready: lcm_data_ready and ssm_data_ready are sampled only on a head flit. Once accepted, a packet is never backpressured.
- Tail-valid rule: the tail's output valid = port2demux_data_valid_wr ? port2demux_data_valid : 1.
- IDLE_S:
  - Head: dest = (data[127:120]==LMID) ? LCM : SSM.
    - If dest is ready, forward the head and go to LCM_RECV_S or SSM_RECV_S.
    - Otherwise increment drop_pkt_cnt and go to DROP_S.
  - Middle, tail or 00: discard, err_cnt+1, stay in IDLE_S.
- LCM_RECV_S and SSM_RECV_S:
  - Middle: forward, stay.
  - Tail: forward with valid_wr=1 and valid per the tail-valid rule. If valid=1, increment that destination's pkt_cnt. Go to IDLE_S.
  - Head (truncated packet):
    - Abort the current destination with valid_wr=1, valid=0, data_wr=0.
    - err_cnt+1. The new head is not forwarded; go to DROP_S.
  - 00: abort as above, err_cnt+1, go to IDLE_S.
- DROP_S:
  - Discard flits until a tail, then go to IDLE_S.
  - A head here is evaluated exactly as in IDLE_S, and err_cnt+1.
  - 00: err_cnt+1, go to IDLE_S.
- Counters: wrap modulo 2^CNT_W. Within one cycle, at most one increment per counter.
- Invariant: LCM and SSM outputs are never both written in the same cycle.

Decomposition:
- Shared package: flit type codes HEAD=2'b01, MID=2'b11, TAIL=2'b10, NONE=2'b00; the field slices [133:132] and [127:120]; the state encodings IDLE_S, LCM_RECV_S, SSM_RECV_S, DROP_S. These are shared with mux.
- Counter block: a single module, demux_stat_cnt, parameterised by CNT_W, with an increment and a clear input. It is instantiated four times.

Test Plan:
- Route to LCM:
  - Stimulus: lcm_data_ready=1; 3-flit packet with head[127:120]=8'd5, tail valid_wr=1, valid=1.
  - Response: 3 flits on demux2lcm, each 1 cycle later; valid_wr and valid high with the tail; lcm_pkt_cnt=1; demux2ssm silent.
- Route to SSM:
  - Stimulus: head[127:120]=8'd9, 4 flits, 2 idle gap cycles between middles.
  - Response: flits appear on demux2ssm with the gaps preserved; ssm_pkt_cnt=1.
- Drop on not-ready:
  - Stimulus: lcm_data_ready=0; LMID packet of 5 flits, then a good LCM packet with ready=1.
  - Response: first packet absent from all outputs, drop_pkt_cnt=1; second packet delivered intact.
- Truncation:
  - Stimulus: an SSM packet's head and middle, then a new head with no tail in between.
  - Response: demux2ssm_data_valid_wr=1, valid=0 one cycle later; err_cnt=1; the new packet is dropped through its tail; state returns to IDLE_S.
- Orphan flits:
  - Stimulus: a middle and a tail with no head.
  - Response: no output; err_cnt=2.
- Reset mid-packet:
  - Stimulus: rst=1 for 1 cycle after an LCM head, then the remaining flits arrive.
  - Response: all outputs 0 and counters 0; the orphan middle and tail give err_cnt=2.
